// File: rtl/mips_mc_fsm_control_if.sv
// rtl/mips_mc_fsm_control_if.sv - controller/datapath bundle for the multi-cycle MIPS main control
interface mips_mc_fsm_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       instr_write;
    logic       mem_to_reg_sel;
    logic       reg_dest;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_error;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, branch, iord, mem_read, mem_write, instr_write,
               mem_to_reg_sel, reg_dest, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, instr_done, illegal_op, bus_error, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, branch, iord, mem_read, mem_write, instr_write,
               mem_to_reg_sel, reg_dest, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, instr_done, illegal_op, bus_error, state
    );
endinterface

// File: rtl/mips_mc_fsm_control.sv
// rtl/mips_mc_fsm_control.sv - multi-cycle MIPS main control FSM with mem_ready wait/timeout
module mips_mc_fsm_control #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input logic                  clock,
    input logic                  reset,
    mips_mc_fsm_control_if.master ctl
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REX    = 4'd7,
        S_RWB    = 4'd8,
        S_BEQEX  = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JEX    = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);

    state_t           st;
    logic [TMO_W-1:0] wait_cnt;
    logic             ill_q;
    logic             bus_q;

    logic             tmo_hit;
    logic [TMO_W-1:0] wait_inc;

    // mem_ready in the timeout cycle wins, so the trap requires mem_ready low
    assign tmo_hit  = (MEM_TIMEOUT != 0) && (wait_cnt == TMO_LIM) && !ctl.mem_ready;
    assign wait_inc = (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;

    // wait_cnt defaults to zero so every transition into a wait state starts clean
    always_ff @(posedge clock) begin
        if (reset) begin
            st       <= S_IDLE;
            wait_cnt <= '0;
            ill_q    <= 1'b0;
            bus_q    <= 1'b0;
        end else begin
            wait_cnt <= '0;
            case (st)
                S_IDLE: st <= S_FETCH;
                S_FETCH: begin
                    if (ctl.mem_ready) begin
                        st <= S_DECODE;
                    end else if (tmo_hit) begin
                        st    <= S_TRAP;
                        bus_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                S_DECODE: begin
                    case (ctl.opcode)
                        OP_RTYPE:     st <= S_REX;
                        OP_LW, OP_SW: st <= S_MEMADR;
                        OP_BEQ:       st <= S_BEQEX;
                        OP_ADDI:      st <= S_ADDIEX;
                        OP_J:         st <= S_JEX;
                        default: begin
                            st    <= S_TRAP;
                            ill_q <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: st <= (ctl.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (ctl.mem_ready) begin
                        st <= S_MEMWB;
                    end else if (tmo_hit) begin
                        st    <= S_TRAP;
                        bus_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                S_MEMWR: begin
                    if (ctl.mem_ready) begin
                        st <= S_FETCH;
                    end else if (tmo_hit) begin
                        st    <= S_TRAP;
                        bus_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                S_REX:    st <= S_RWB;
                S_ADDIEX: st <= S_ADDIWB;
                S_MEMWB, S_RWB, S_BEQEX, S_ADDIWB, S_JEX: st <= S_FETCH;
                S_TRAP:   st <= S_TRAP;
                default: begin
                    st    <= S_TRAP;
                    ill_q <= 1'b1;
                end
            endcase
        end
    end

    assign ctl.state      = st;
    assign ctl.illegal_op = ill_q;
    assign ctl.bus_error  = bus_q;

    // Moore decode of the registered state; only FETCH/MEMWR look at mem_ready
    always_comb begin
        ctl.pc_write       = 1'b0;
        ctl.branch         = 1'b0;
        ctl.iord           = 1'b0;
        ctl.mem_read       = 1'b0;
        ctl.mem_write      = 1'b0;
        ctl.instr_write    = 1'b0;
        ctl.mem_to_reg_sel = 1'b0;
        ctl.reg_dest       = 1'b0;
        ctl.reg_write      = 1'b0;
        ctl.alu_src_a      = 1'b0;
        ctl.alu_src_b      = 2'b00;
        ctl.alu_op         = 2'b00;
        ctl.pc_source      = 2'b00;
        ctl.instr_done     = 1'b0;
        case (st)
            S_FETCH: begin
                ctl.mem_read    = 1'b1;
                ctl.alu_src_b   = 2'b01;
                ctl.pc_write    = ctl.mem_ready;
                ctl.instr_write = ctl.mem_ready;
            end
            S_DECODE: ctl.alu_src_b = 2'b11;
            S_MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                ctl.iord     = 1'b1;
                ctl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctl.reg_write      = 1'b1;
                ctl.mem_to_reg_sel = 1'b1;
                ctl.instr_done     = 1'b1;
            end
            S_MEMWR: begin
                ctl.iord       = 1'b1;
                ctl.mem_write  = 1'b1;
                ctl.instr_done = ctl.mem_ready;
            end
            S_REX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = 2'b10;
            end
            S_RWB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dest   = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_BEQEX: begin
                ctl.alu_src_a  = 1'b1;
                ctl.alu_op     = 2'b01;
                ctl.pc_source  = 2'b01;
                ctl.branch     = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_JEX: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_source  = 2'b10;
                ctl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_fsm_control.sv
// tb/tb_mips_mc_fsm_control.sv - bench for mips_mc_fsm_control with per-instruction step-plan model
module tb_mips_mc_fsm_control;

    localparam int TMO = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    mips_mc_fsm_control_if bus ();

    mips_mc_fsm_control #(.MEM_TIMEOUT(TMO), .TMO_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .ctl   (bus.master)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // {pc_write,branch,iord,mem_read,mem_write,instr_write,mem_to_reg_sel,reg_dest,
    //  reg_write,alu_src_a,alu_src_b,alu_op,pc_source,instr_done}
    function automatic logic [16:0] exp_out(input int st, input logic r);
        logic pcw = 0, br = 0, io = 0, mr = 0, mw = 0, iw = 0, m2r = 0, rd = 0, rw = 0, sa = 0, dn = 0;
        logic [1:0] sb = 0, op = 0, ps = 0;
        case (st)
            1:  begin pcw = r; iw = r; mr = 1; sb = 2'b01; end
            2:  sb = 2'b11;
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin io = 1; mr = 1; end
            5:  begin rw = 1; m2r = 1; dn = 1; end
            6:  begin io = 1; mw = 1; dn = r; end
            7:  begin sa = 1; op = 2'b10; end
            8:  begin rw = 1; rd = 1; dn = 1; end
            9:  begin sa = 1; op = 2'b01; ps = 2'b01; br = 1; dn = 1; end
            10: begin sa = 1; sb = 2'b10; end
            11: begin rw = 1; dn = 1; end
            12: begin pcw = 1; ps = 2'b10; dn = 1; end
            default: ;
        endcase
        return {pcw, br, io, mr, mw, iw, m2r, rd, rw, sa, sb, op, ps, dn};
    endfunction

    // Model: current step, remaining steps of the instruction, wait count, trap flags
    int   m_st;
    int   m_plan[$];
    int   m_wait;
    bit   m_ill, m_bus, m_valid;
    logic [16:0] dvec;

    always @(negedge clock) begin
        if (m_valid) begin
            dvec = {bus.pc_write, bus.branch, bus.iord, bus.mem_read, bus.mem_write,
                    bus.instr_write, bus.mem_to_reg_sel, bus.reg_dest, bus.reg_write,
                    bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done};
            chk("cycle", int'({bus.illegal_op, bus.bus_error, bus.state, dvec}),
                int'({m_ill, m_bus, 4'(m_st), exp_out(m_st, bus.mem_ready)}));
        end
        if (reset) begin
            m_st = 0; m_wait = 0; m_ill = 0; m_bus = 0; m_plan.delete(); m_valid = 1;
        end else if (m_valid && m_st != 13) begin
            if ((m_st == 1 || m_st == 4 || m_st == 6) && !bus.mem_ready) begin
                if (m_wait == TMO) begin m_st = 13; m_bus = 1; end
                else m_wait++;
            end else begin
                m_wait = 0;
                if (m_st == 0) m_st = 1;
                else if (m_st == 1) m_st = 2;
                else if (m_st == 2) begin
                    case (bus.opcode)
                        6'b000000: m_plan = '{7, 8};
                        6'b100011: m_plan = '{3, 4, 5};
                        6'b101011: m_plan = '{3, 6};
                        6'b000100: m_plan = '{9};
                        6'b001000: m_plan = '{10, 11};
                        6'b000010: m_plan = '{12};
                        default:   m_plan = '{13};
                    endcase
                    m_st = m_plan.pop_front();
                    if (m_st == 13) m_ill = 1;
                end else if (m_plan.size() > 0) m_st = m_plan.pop_front();
                else m_st = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic run_instr(input logic [5:0] op, input int stalls,
                             output int cyc, output int mw, output int rw);
        int  left = stalls;
        bit  done = 0;
        cyc = 0; mw = 0; rw = 0;
        bus.opcode = op;
        for (int i = 0; i < 40 && !done; i++) begin
            if (bus.state == 4'd4 && left > 0) begin
                bus.mem_ready = 1'b0;
                left--;
            end else begin
                bus.mem_ready = 1'b1;
            end
            #1;
            cyc++;
            mw += int'(bus.mem_write);
            rw += int'(bus.reg_write);
            done = bus.instr_done;
            tick();
        end
        chk("instr_done_seen", int'(done), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seqv, pcw_n, done_n, rwb_ok, cyc, mw, rw, n;
        bus.opcode    = 6'b000000;
        bus.mem_ready = 1'b1;
        reset         = 1'b1;
        tick(); tick(); tick();
        chk("reset_state", int'(bus.state), 0);
        chk("reset_pc_write", int'(bus.pc_write), 0);
        reset = 1'b0;

        seqv = 0; pcw_n = 0; done_n = 0; rwb_ok = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            seqv = (seqv << 4) | int'(bus.state);
            if (i < 5) begin
                pcw_n  += int'(bus.pc_write);
                done_n += int'(bus.instr_done);
                if (bus.state == 4'd8 && bus.reg_write && bus.reg_dest) rwb_ok++;
                tick();
            end
        end
        chk("rtype_state_seq", seqv, 32'h012781);
        chk("rtype_pc_write_cycles", pcw_n, 1);
        chk("rtype_instr_done_pulses", done_n, 1);
        chk("rtype_rwb_write_rd", rwb_ok, 1);

        run_instr(6'b100011, 2, cyc, mw, rw);
        chk("lw_stall_cycles", cyc, 7);
        chk("lw_reg_write_cycles", rw, 1);
        run_instr(6'b101011, 0, cyc, mw, rw);
        chk("sw_cycles", cyc, 4);
        chk("sw_mem_write_cycles", mw, 1);
        chk("sw_reg_write_cycles", rw, 0);
        run_instr(6'b000100, 0, cyc, mw, rw);
        chk("beq_cycles", cyc, 3);
        run_instr(6'b000010, 0, cyc, mw, rw);
        chk("j_cycles", cyc, 3);
        run_instr(6'b001000, 0, cyc, mw, rw);
        chk("addi_cycles", cyc, 4);
        chk("addi_reg_write_cycles", rw, 1);
        run_instr(6'b000000, 0, cyc, mw, rw);
        chk("rtype_cycles", cyc, 4);

        bus.opcode = 6'b111111;
        tick(); tick();
        chk("illegal_trap_state", int'(bus.state), 13);
        chk("illegal_flag", int'(bus.illegal_op), 1);
        repeat (20) tick();
        chk("illegal_trap_held", int'(bus.state), 13);
        bus.opcode = 6'b000000;
        reset = 1'b1;
        tick();
        chk("trap_reset_state", int'(bus.state), 0);
        chk("trap_reset_illegal", int'(bus.illegal_op), 0);
        reset = 1'b0;

        bus.mem_ready = 1'b0;
        tick();
        n = 0; pcw_n = 0;
        while (bus.state == 4'd1 && n < 20) begin
            #1;
            pcw_n += int'(bus.pc_write);
            n++;
            tick();
        end
        chk("timeout_fetch_cycles", n, TMO + 1);
        chk("timeout_state", int'(bus.state), 13);
        chk("timeout_bus_error", int'(bus.bus_error), 1);
        chk("timeout_pc_write", pcw_n, 0);

        for (int last = TMO; last <= TMO + 1; last++) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            bus.mem_ready = 1'b0;
            tick();
            for (int k = 1; k <= last; k++) begin
                bus.mem_ready = (k == last);
                tick();
            end
            chk($sformatf("late_ready_%0d_state", last), int'(bus.state), 2);
            chk($sformatf("late_ready_%0d_bus_error", last), int'(bus.bus_error), 0);
        end

        bus.mem_ready = 1'b1;
        tick(); tick(); tick();
        chk("back_to_fetch", int'(bus.state), 1);
        bus.opcode = 6'b101011;
        tick(); tick(); tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("memwr_state", int'(bus.state), 6);
        chk("memwr_strobe", int'(bus.mem_write), 1);
        reset = 1'b1;
        tick();
        chk("abort_state", int'(bus.state), 0);
        chk("abort_mem_write", int'(bus.mem_write), 0);
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        chk("abort_refetch", int'(bus.state), 1);
        tick();
        chk("abort_decode", int'(bus.state), 2);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
